// File: rtl/math_pipelined_sequencer.sv
// math_pipelined_sequencer
//   Issue/collect stage wrapped around an externally instantiated math_pipelined ALU.
//   An operand triplet is accepted over valid/ready and registered onto the ALU inputs.
//   The operands are then held for SETTLE cycles so every chunked carry chain and
//   reduction tree inside the ALU has settled. After that the ALU outputs and the
//   derived carry/overflow flags are captured into an output register that is
//   offered downstream over valid/ready.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid && ready are both high. valid never depends combinationally on ready.
//   in_ready is high only in IDLE. out_valid is high only in OUT.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   in_valid/in_ready         operand handshake; in_I1, in_I2, in_I3 are the operands
//   alu_I1/alu_I2/alu_I3      registered operands driven to the ALU
//   alu_sum/alu_sub/alu_flags ALU results {cmp_neq,cmp_eq,gate_xor,gate_or,gate_and}
//   out_valid/out_ready       result handshake; out_sum, out_sub, out_flags
//                             out_flags = {sub_ovf,sub_borrow,add_ovf,add_carry,
//                                          cmp_neq,cmp_eq,xor,or,and}
//   busy                      high while an operation is in HOLD or OUT
module math_pipelined_sequencer #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 4,
  parameter int SETTLE  = LATENCY + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_I1,
  input  logic [WIDTH-1:0] in_I2,
  input  logic [WIDTH-1:0] in_I3,
  output logic [WIDTH-1:0] alu_I1,
  output logic [WIDTH-1:0] alu_I2,
  output logic [WIDTH-1:0] alu_I3,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic [WIDTH-1:0] alu_sub,
  input  logic [4:0]       alu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_sub,
  output logic [8:0]       out_flags,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Counter only needs to hold SETTLE-1; keep at least one bit for SETTLE==1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  if (SETTLE < 1) begin : g_bad_settle
    $error("math_pipelined_sequencer: SETTLE must be >= 1");
  end
  if (LATENCY < 0) begin : g_bad_latency
    $error("math_pipelined_sequencer: LATENCY must be >= 0");
  end

  // Current FSM state; kept as a named signal so checkers can bind to it.
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic add_carry;
  logic add_ovf;
  logic sub_borrow;
  logic sub_ovf;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign busy      = (state != ST_IDLE);

  // Derived flags use the held operands, which are still on alu_I* at capture.
  always_comb begin
    add_carry  = (alu_sum < alu_I1);
    add_ovf    = (alu_I1[WIDTH-1] == alu_I2[WIDTH-1]) && (alu_sum[WIDTH-1] != alu_I1[WIDTH-1]);
    sub_borrow = (alu_I1 < alu_I2);
    sub_ovf    = (alu_I1[WIDTH-1] != alu_I2[WIDTH-1]) && (alu_sub[WIDTH-1] != alu_I1[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_I1    <= '0;
      alu_I2    <= '0;
      alu_I3    <= '0;
      out_sum   <= '0;
      out_sub   <= '0;
      out_flags <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_I1 <= in_I1;
            alu_I2 <= in_I2;
            alu_I3 <= in_I3;
            cnt    <= CW'(SETTLE - 1);
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The edge that sees cnt==0 is accept edge + SETTLE.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            out_sum   <= alu_sum;
            out_sub   <= alu_sub;
            out_flags <= {sub_ovf, sub_borrow, add_ovf, add_carry, alu_flags};
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          // Returning to IDLE first means no accept shares the output handshake edge.
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Results stay put while stalled downstream.
  a_out_stable: assert property (@(posedge clk)
    (out_valid && !out_ready && !rst) |=> $stable({out_sum, out_sub, out_flags}));

  // Operands on the ALU never move while an operation is in flight.
  a_alu_stable: assert property (@(posedge clk)
    (busy && !rst) |=> $stable({alu_I1, alu_I2, alu_I3}));

endmodule

// File: tb/tb_math_pipelined_sequencer.sv
// Testbench for math_pipelined_sequencer with WIDTH=8, LATENCY=4, SETTLE=5.
// A small latency-accurate stand-in for the math_pipelined ALU is built here: its
// outputs only reflect new operands LATENCY cycles after they change, so capturing
// early would pick up stale results.
module tb_math_pipelined_sequencer;

  localparam int W   = 8;
  localparam int LAT = 4;
  localparam int ST  = 5;
  localparam int RW  = W + W + 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_I1 = '0, in_I2 = '0, in_I3 = '0;
  logic [W-1:0] alu_I1, alu_I2, alu_I3;
  logic [W-1:0] alu_sum, alu_sub;
  logic [4:0]   alu_flags;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum, out_sub;
  logic [8:0]   out_flags;
  logic         busy;

  math_pipelined_sequencer #(.WIDTH(W), .LATENCY(LAT), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_I1(in_I1), .in_I2(in_I2), .in_I3(in_I3),
    .alu_I1(alu_I1), .alu_I2(alu_I2), .alu_I3(alu_I3),
    .alu_sum(alu_sum), .alu_sub(alu_sub), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_sub(out_sub), .out_flags(out_flags),
    .busy(busy)
  );

  // ---------------- ALU stand-in (LAT register stages) ----------------
  logic [W-1:0] p_sum [LAT];
  logic [W-1:0] p_sub [LAT];
  logic [4:0]   p_flg [LAT];

  always @(posedge clk) begin
    p_sum[0] <= alu_I1 + alu_I2;
    p_sub[0] <= alu_I1 - alu_I2;
    p_flg[0] <= {alu_I1 != alu_I3, alu_I1 == alu_I3, ^(alu_I1 ^ alu_I2),
                 |(alu_I1 | alu_I2), &(alu_I1 & alu_I2)};
    for (int i = 1; i < LAT; i++) begin
      p_sum[i] <= p_sum[i-1];
      p_sub[i] <= p_sub[i-1];
      p_flg[i] <= p_flg[i-1];
    end
  end
  assign alu_sum   = p_sum[LAT-1];
  assign alu_sub   = p_sub[LAT-1];
  assign alu_flags = p_flg[LAT-1];

  // ---------------- reference model ----------------
  // Plain integer arithmetic: returns {sum, sub, flags}.
  function automatic logic [RW-1:0] ref_model(input logic [W-1:0] a, b, c);
    int ua, ub, sa, sb, ssum, sdif;
    logic [W-1:0] s, d;
    logic carry, aovf, borrow, sovf;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    s = W'((ua + ub) % (2**W));
    d = W'((ua - ub + 2**W) % (2**W));
    carry  = (ua + ub) >= 2**W;
    borrow = ua < ub;
    ssum = sa + sb;
    sdif = sa - sb;
    aovf = (ssum > 2**(W-1) - 1) || (ssum < -(2**(W-1)));
    sovf = (sdif > 2**(W-1) - 1) || (sdif < -(2**(W-1)));
    return {s, d, sovf, borrow, aovf, carry, a != c, a == c, ^(a ^ b), |(a | b), &(a & b)};
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every output handshake pops one expected result.
  logic [RW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_output", 32'(out_sum), 32'hDEAD);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        check("sb_sum",   32'(out_sum),   32'(e[RW-1 -: W]));
        check("sb_sub",   32'(out_sub),   32'(e[RW-W-1 -: W]));
        check("sb_flags", 32'(out_flags), 32'(e[8:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at #1 after an edge. Offers a triplet, waits for the accept edge and
  // returns the number of edges from accept until out_valid is seen.
  task automatic run_op(input logic [W-1:0] a, b, c, input bit score, output int lat);
    int guard;
    in_I1 = a; in_I2 = b; in_I3 = c; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    if (score) exp_q.push_back(ref_model(a, b, c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] i1, i2, i3;
    logic [W-1:0] sum, sub;
    logic [5:0]   hi;   // {sub_ovf, sub_borrow, add_ovf, add_carry, cmp_neq, cmp_eq}
  } vec_t;

  vec_t vecs[7];

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    logic [RW-1:0] e;
    int last_acc;
    bit seen;

    vecs[0] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 8'hFE, 6'b000101};
    vecs[1] = '{8'h7F, 8'h01, 8'h00, 8'h80, 8'h7E, 6'b001010};
    vecs[2] = '{8'h80, 8'h01, 8'h00, 8'h81, 8'h7F, 6'b100010};
    vecs[3] = '{8'h03, 8'h05, 8'h04, 8'h08, 8'hFE, 6'b010010};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 6'b000001};
    vecs[5] = '{8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 6'b001101};
    vecs[6] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hFF, 6'b010001};

    // ---- reset state ----
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_alu_ops",   32'({alu_I1, alu_I2, alu_I3}), 32'd0);
    check("rst_out_regs",  32'({out_sum, out_sub, out_flags}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- idle with in_valid low: nothing moves ----
    repeat (3) begin @(posedge clk); #1; end
    check("idle_busy",    32'(busy),     32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // ---- directed table ----
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      run_op(vecs[k].i1, vecs[k].i2, vecs[k].i3, 1'b1, lat);
      e = ref_model(vecs[k].i1, vecs[k].i2, vecs[k].i3);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(ST));
      check($sformatf("vec%0d_sum", k), 32'(out_sum), 32'(vecs[k].sum));
      check($sformatf("vec%0d_sub", k), 32'(out_sub), 32'(vecs[k].sub));
      check($sformatf("vec%0d_flags_hi", k), 32'(out_flags[8:3]), 32'(vecs[k].hi));
      check($sformatf("vec%0d_gates", k), 32'(out_flags[2:0]), 32'(e[2:0]));
      check($sformatf("vec%0d_busy_in_out", k), 32'({busy, in_ready}), 32'b10);
      @(posedge clk); #1;
      check($sformatf("vec%0d_back_to_idle", k), 32'({out_valid, in_ready}), 32'b01);
    end

    // ---- backpressure: 10 stalled cycles ----
    out_ready = 1'b0;
    run_op(8'h7F, 8'h01, 8'h00, 1'b1, lat);
    e = ref_model(8'h7F, 8'h01, 8'h00);
    check("bp_latency", 32'(lat), 32'(ST));
    in_I1 = 8'h11; in_I2 = 8'h22; in_I3 = 8'h33; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
      check("bp_out_regs",  32'({out_sum, out_sub, out_flags}), 32'(e));
      check("bp_alu_held",  32'(alu_I1), 32'h7F);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'({out_valid, in_ready, busy}), 32'b010);

    // ---- back-to-back random triplets ----
    last_acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int guard;
      logic [W-1:0] a, b, c;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      c = ($urandom_range(0, 3) == 0) ? a : W'($urandom_range(0, 255));
      in_I1 = a; in_I2 = b; in_I3 = c;
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      check("b2b_ready", 32'(in_ready), 32'd1);
      exp_q.push_back(ref_model(a, b, c));
      if (k > 0) check("b2b_interval", 32'(cyc - last_acc), 32'(ST + 2));
      last_acc = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
        @(posedge clk); #1; guard++;
      end
    end
    check("b2b_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // ---- reset in HOLD at cnt==2 drops the op ----
    in_I1 = 8'h12; in_I2 = 8'h34; in_I3 = 8'h56; in_valid = 1'b1;
    check("rsth_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;           // accept edge, cnt = 4
    in_valid = 1'b0;
    @(posedge clk); #1;           // cnt = 3
    @(posedge clk); #1;           // cnt = 2
    check("rsth_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rsth_idle", 32'({out_valid, in_ready, busy}), 32'b010);
    check("rsth_alu_cleared", 32'({alu_I1, alu_I2, alu_I3}), 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rsth_no_output", 32'(seen), 32'd0);
    run_op(8'h03, 8'h05, 8'h04, 1'b1, lat);
    check("rsth_next_latency", 32'(lat), 32'(ST));
    check("rsth_next_sum", 32'(out_sum), 32'h08);
    check("rsth_next_sub", 32'(out_sub), 32'hFE);
    @(posedge clk); #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
